matrix_stream_tiler: RTL and testbench

Converts a row-major element stream of a TOTAL_DIM1 x TOTAL_DIM0 matrix into the compute-sub-block stream consumed by the sparse and dense matmul blocks. Sub-blocks are COMPUTE_DIM1 rows x COMPUTE_DIM0 columns and are emitted in row-major block order. It sits upstream of matmul port A or B, between a DMA/row source and the matmul. A ping-pong pair of strip buffers lets the tiler fill one strip of COMPUTE_DIM1 rows while the previous strip is emitted.

---
 rtl/matrix_stream_tiler_if.sv | 25 ++
 rtl/matrix_stream_tiler_tile_bank.sv | 37 +++
 rtl/matrix_stream_tiler.sv | 112 +++++++++++
 tb/tb_matrix_stream_tiler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_tiler_if.sv
// Stream bundle for the tiler: row-chunk beats in, compute sub-blocks out.
// The slave side is the tiler; the master side is the row source plus the matmul sink.
interface matrix_stream_tiler_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2
);
  logic [COMPUTE_DIM0-1:0][DATA_WIDTH-1:0]              in_data;
  logic                                                 in_valid;
  logic                                                 in_ready;
  logic [COMPUTE_DIM1*COMPUTE_DIM0-1:0][DATA_WIDTH-1:0] out_data;
  logic                                                 out_valid;
  logic                                                 out_ready;
  logic                                                 out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/matrix_stream_tiler_tile_bank.sv
// One strip of register storage: DEPTH_DIM0 sub-blocks of COMPUTE_DIM1 rows.
// Row-granular write port, whole-sub-block combinational read port.
module tile_bank #(
  parameter int DATA_WIDTH   = 8,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2,
  parameter int DEPTH_DIM0   = 2,
  parameter int BLK_W        = 1,
  parameter int ROW_W        = 1
) (
  input  logic                                                 clk,
  input  logic                                                 we,
  input  logic [BLK_W-1:0]                                     wr_blk,
  input  logic [ROW_W-1:0]                                     wr_row,
  input  logic [COMPUTE_DIM0-1:0][DATA_WIDTH-1:0]              wr_data,
  input  logic [BLK_W-1:0]                                     rd_blk,
  output logic [COMPUTE_DIM1*COMPUTE_DIM0-1:0][DATA_WIDTH-1:0] rd_data
);
  // Row-major packing makes each sub-block's bits line up with out_data element order.
  logic [DEPTH_DIM0-1:0][COMPUTE_DIM1-1:0][COMPUTE_DIM0-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < DEPTH_DIM0; b++)
      for (int r = 0; r < COMPUTE_DIM1; r++)
        if (we && wr_blk == BLK_W'(b) && wr_row == ROW_W'(r))
          mem_d[b][r] = wr_data;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_comb begin
    rd_data = '0;
    for (int b = 0; b < DEPTH_DIM0; b++)
      if (rd_blk == BLK_W'(b)) rd_data = mem_q[b];
  end
endmodule

// File: rtl/matrix_stream_tiler.sv
// Row-major stream to compute-sub-block stream, via a ping-pong pair of strip banks.
// One bank fills with COMPUTE_DIM1 rows while the other is emitted block by block.
module matrix_stream_tiler #(
  parameter int DATA_WIDTH   = 8,
  parameter int TOTAL_DIM0   = 4,
  parameter int TOTAL_DIM1   = 4,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2
) (
  input logic               clk,
  input logic               rst,
  matrix_stream_tiler_if.slave s
);
  localparam int DEPTH_DIM0 = TOTAL_DIM0 / COMPUTE_DIM0;
  localparam int DEPTH_DIM1 = TOTAL_DIM1 / COMPUTE_DIM1;
  localparam int CB_W       = (DEPTH_DIM0 > 1) ? $clog2(DEPTH_DIM0) : 1;
  localparam int ROW_W      = (COMPUTE_DIM1 > 1) ? $clog2(COMPUTE_DIM1) : 1;
  localparam int STRIP_W    = (DEPTH_DIM1 > 1) ? $clog2(DEPTH_DIM1) : 1;

  logic               wb_q, wb_d, rb_q, rb_d;
  logic [1:0]         full_q, full_d;
  logic [ROW_W-1:0]   wrow_q, wrow_d;
  logic [CB_W-1:0]    wcb_q, wcb_d, rcb_q, rcb_d;
  logic [STRIP_W-1:0] rstrip_q, rstrip_d;
  logic               in_ready, out_valid, wr_fire, rd_fire;
  logic [1:0][COMPUTE_DIM1*COMPUTE_DIM0-1:0][DATA_WIDTH-1:0] bank_rd;

  assign in_ready    = !full_q[wb_q];
  assign out_valid   = full_q[rb_q];
  assign wr_fire     = s.in_valid && in_ready;
  assign rd_fire     = out_valid && s.out_ready;
  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_data  = bank_rd[rb_q];
  assign s.out_last  = out_valid && rstrip_q == STRIP_W'(DEPTH_DIM1-1)
                       && rcb_q == CB_W'(DEPTH_DIM0-1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COMPUTE_DIM0(COMPUTE_DIM0),
      .COMPUTE_DIM1(COMPUTE_DIM1),
      .DEPTH_DIM0  (DEPTH_DIM0),
      .BLK_W       (CB_W),
      .ROW_W       (ROW_W)
    ) u_bank (
      .clk    (clk),
      .we     (wr_fire && wb_q == 1'(b)),
      .wr_blk (wcb_q),
      .wr_row (wrow_q),
      .wr_data(s.in_data),
      .rd_blk (rcb_q),
      .rd_data(bank_rd[b])
    );
  end

  // A write only lands on an empty bank and a read only on a full one,
  // so the set and clear below never target the same flag in one cycle.
  always_comb begin
    wb_d     = wb_q;
    wrow_d   = wrow_q;
    wcb_d    = wcb_q;
    rb_d     = rb_q;
    rcb_d    = rcb_q;
    rstrip_d = rstrip_q;
    full_d   = full_q;
    if (wr_fire) begin
      if (wcb_q == CB_W'(DEPTH_DIM0-1)) begin
        wcb_d = '0;
        if (wrow_q == ROW_W'(COMPUTE_DIM1-1)) begin
          wrow_d       = '0;
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
        end else begin
          wrow_d = wrow_q + 1'b1;
        end
      end else begin
        wcb_d = wcb_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rcb_q == CB_W'(DEPTH_DIM0-1)) begin
        rcb_d        = '0;
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rstrip_d     = (rstrip_q == STRIP_W'(DEPTH_DIM1-1)) ? '0 : rstrip_q + 1'b1;
      end else begin
        rcb_d = rcb_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= 1'b0;
      wrow_q   <= '0;
      wcb_q    <= '0;
      rb_q     <= 1'b0;
      rcb_q    <= '0;
      rstrip_q <= '0;
      full_q   <= '0;
    end else begin
      wb_q     <= wb_d;
      wrow_q   <= wrow_d;
      wcb_q    <= wcb_d;
      rb_q     <= rb_d;
      rcb_q    <= rcb_d;
      rstrip_q <= rstrip_d;
      full_q   <= full_d;
    end
  end
endmodule

// File: tb/tb_matrix_stream_tiler.sv
// Directed bench for matrix_stream_tiler: 4x4/2x2 main instance plus a
// degenerate 2x2/2x2 instance and a non-square 2x8/2x2 instance.
module tb_matrix_stream_tiler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   in_beat = 0;
  int   out_blk = 0;

  always #5 clk = ~clk;

  matrix_stream_tiler_if #(.DATA_WIDTH(8), .COMPUTE_DIM0(2), .COMPUTE_DIM1(2)) m_if ();
  matrix_stream_tiler_if #(.DATA_WIDTH(8), .COMPUTE_DIM0(2), .COMPUTE_DIM1(2)) d_if ();
  matrix_stream_tiler_if #(.DATA_WIDTH(8), .COMPUTE_DIM0(2), .COMPUTE_DIM1(2)) n_if ();

  matrix_stream_tiler #(.DATA_WIDTH(8), .TOTAL_DIM0(4), .TOTAL_DIM1(4),
                        .COMPUTE_DIM0(2), .COMPUTE_DIM1(2))
    u_main (.clk(clk), .rst(rst), .s(m_if));
  matrix_stream_tiler #(.DATA_WIDTH(8), .TOTAL_DIM0(2), .TOTAL_DIM1(2),
                        .COMPUTE_DIM0(2), .COMPUTE_DIM1(2))
    u_deg (.clk(clk), .rst(rst), .s(d_if));
  matrix_stream_tiler #(.DATA_WIDTH(8), .TOTAL_DIM0(8), .TOTAL_DIM1(2),
                        .COMPUTE_DIM0(2), .COMPUTE_DIM1(2))
    u_nsq (.clk(clk), .rst(rst), .s(n_if));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Matrix k of the main stream holds k*16 + r*4 + c.
  function automatic logic [7:0] mval(int k, int r, int c);
    return 8'(k * 16 + r * 4 + c);
  endfunction

  function automatic logic [15:0] mbeat(int b);
    int k, bb;
    k  = b / 8;
    bb = b % 8;
    return {mval(k, bb / 2, (bb % 2) * 2 + 1), mval(k, bb / 2, (bb % 2) * 2)};
  endfunction

  function automatic logic [31:0] mblk(int n);
    int k, s, c;
    k = n / 4;
    s = (n % 4) / 2;
    c = n % 2;
    return {mval(k, 2*s+1, 2*c+1), mval(k, 2*s+1, 2*c), mval(k, 2*s, 2*c+1), mval(k, 2*s, 2*c)};
  endfunction

  task automatic main_cycle(input logic iv, input logic ordy);
    m_if.in_valid  = iv;
    m_if.in_data   = mbeat(in_beat);
    m_if.out_ready = ordy;
    #1;
    if (m_if.out_valid && ordy) begin
      chk("m_blk", m_if.out_data, mblk(out_blk));
      chk("m_last", m_if.out_last, 32'((out_blk % 4) == 3));
      out_blk++;
    end
    if (iv && m_if.in_ready) in_beat++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int db, dn, nb, nn;
    m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.out_ready = 1'b0;
    d_if.in_valid = 1'b0; d_if.in_data = '0; d_if.out_ready = 1'b0;
    n_if.in_valid = 1'b0; n_if.in_data = '0; n_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", m_if.in_ready, 1);
    chk("rst_out_valid", m_if.out_valid, 0);
    chk("rst_out_last", m_if.out_last, 0);
    chk("rst_d_ready", d_if.in_ready, 1);
    chk("rst_n_valid", n_if.out_valid, 0);

    // Unstalled stream: first block one cycle after the 4th beat.
    for (int i = 0; i < 4; i++) begin
      chk("lat_pre", m_if.out_valid, 0);
      main_cycle(1'b1, 1'b1);
    end
    chk("lat_first", m_if.out_valid, 1);
    for (int i = 0; i < 20 && out_blk < 4; i++) main_cycle(1'(in_beat < 8), 1'b1);
    chk("nostall_blks", out_blk, 4);
    chk("nostall_beats", in_beat, 8);

    // Backpressure: two strips fit, then in_ready drops.
    for (int i = 0; i < 12; i++) main_cycle(1'b1, 1'b0);
    chk("bp_accepted", in_beat, 16);
    chk("bp_in_ready", m_if.in_ready, 0);
    chk("bp_out_valid", m_if.out_valid, 1);
    main_cycle(1'b0, 1'b1);
    chk("bp_ready_after1", m_if.in_ready, 0);
    main_cycle(1'b0, 1'b1);
    chk("bp_ready_after2", m_if.in_ready, 1);
    main_cycle(1'b0, 1'b1);
    main_cycle(1'b0, 1'b1);
    chk("bp_drained", out_blk, 8);
    chk("bp_idle", m_if.out_valid, 0);

    // Random handshakes, three back-to-back matrices.
    for (int i = 0; i < 3000 && out_blk < 20; i++)
      main_cycle((in_beat < 40) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
    chk("rnd_blks", out_blk, 20);
    chk("rnd_beats", in_beat, 40);

    // Reset after 3 beats of a fresh matrix.
    for (int i = 0; i < 3; i++) main_cycle(1'b1, 1'b0);
    m_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", m_if.in_ready, 1);
    chk("mid_rst_out_valid", m_if.out_valid, 0);
    chk("mid_rst_out_last", m_if.out_last, 0);
    in_beat = 48;
    out_blk = 24;
    for (int i = 0; i < 100 && out_blk < 28; i++) main_cycle(1'(in_beat < 56), 1'b1);
    chk("post_rst_blks", out_blk, 28);
    m_if.in_valid = 1'b0;

    // Degenerate 2x2: every two beats is a whole matrix.
    db = 0;
    dn = 0;
    d_if.out_ready = 1'b1;
    for (int i = 0; i < 30 && dn < 3; i++) begin
      d_if.in_valid = 1'(db < 6);
      d_if.in_data  = {8'(db * 2 + 1), 8'(db * 2)};
      #1;
      if (d_if.out_valid) begin
        chk("d_blk", d_if.out_data, {8'(dn*4+3), 8'(dn*4+2), 8'(dn*4+1), 8'(dn*4)});
        chk("d_last", d_if.out_last, 1);
        dn++;
      end
      if (d_if.in_valid && d_if.in_ready) db++;
      @(posedge clk);
      #1;
    end
    d_if.in_valid = 1'b0;
    chk("d_blks", dn, 3);

    // Non-square 2 rows x 8 columns, value r*8+c.
    nb = 0;
    nn = 0;
    n_if.out_ready = 1'b1;
    for (int i = 0; i < 40 && nn < 4; i++) begin
      n_if.in_valid = 1'(nb < 8);
      n_if.in_data  = {8'((nb / 4) * 8 + (nb % 4) * 2 + 1), 8'((nb / 4) * 8 + (nb % 4) * 2)};
      #1;
      if (n_if.out_valid) begin
        chk("n_blk", n_if.out_data, {8'(9 + 2*nn), 8'(8 + 2*nn), 8'(2*nn + 1), 8'(2*nn)});
        chk("n_last", n_if.out_last, 32'(nn == 3));
        nn++;
      end
      if (n_if.in_valid && n_if.in_ready) nb++;
      @(posedge clk);
      #1;
    end
    n_if.in_valid = 1'b0;
    chk("n_blks", nn, 4);
    chk("n_beats", nb, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
